// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing detector: default counter width,
// lock FSM states and the nominal 640x480 raster constants.
package video_timing_pkg;

    localparam int CW_DEFAULT = 12;

    // Nominal 480p raster (pixels per line / lines per frame)
    localparam int H_TOTAL      = 800;
    localparam int H_ACTIVE     = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int V_TOTAL      = 525;
    localparam int V_ACTIVE     = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sync_edge_meter.sv
// Rising-edge detector with a saturating period counter.
// The counter advances on i_en; on each rising edge the number of enables
// seen since the previous edge (including the edge cycle) is latched.
module sync_edge_meter #(
    parameter int CW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_sync,
    input  logic          i_en,
    output logic          o_rise,
    output logic [CW-1:0] o_period,
    output logic [CW-1:0] o_measure,
    output logic          o_sat
);

    localparam logic [CW-1:0] CMAX = '1;

    logic          r_prev;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_period;
    logic [CW-1:0] w_next;

    assign o_sat     = (r_count == CMAX);
    assign w_next    = o_sat ? CMAX : r_count + 1'b1;
    assign o_rise    = i_sync & ~r_prev;
    assign o_measure = i_en ? w_next : r_count;
    assign o_period  = r_period;

    // Second sync stage, period counter and latched result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev   <= 1'b0;
            r_count  <= '0;
            r_period <= '0;
        end else begin
            r_prev <= i_sync;
            if (o_rise) begin
                r_period <= o_measure;
                r_count  <= '0;
            end else if (i_en) begin
                r_count <= w_next;
            end
        end
    end

endmodule

// File: rtl/video_timing_detector.sv
// Receive-side video timing detector: measures line/frame geometry from a
// pixel-synchronous hsync/vsync/de stream, recovers active coordinates and
// declares lock after two identical consecutive frame measurements.
// Optional macro POLARITY_DETECT_EN: learn sync polarity at each de rise.
module video_timing_detector
    import video_timing_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_de_out,
    output logic          o_frame_start,
    output logic [CW-1:0] o_h_total,
    output logic [CW-1:0] o_h_active,
    output logic [CW-1:0] o_v_total,
    output logic [CW-1:0] o_v_active,
    output logic          o_locked,
    output logic          o_hpol,
    output logic          o_vpol
);

    localparam logic [CW-1:0] CMAX = '1;

    logic            r_hsQ, r_vsQ, r_deQ, r_deQ2;
    logic            w_hpol, w_vpol, w_hs, w_vs;
    logic            w_deRise, w_deFall;
    logic            w_hsRise, w_vsRise, w_hSat, w_vSat;
    logic [CW-1:0]   w_hTotal, w_hMeasure, w_vTotal, w_vMeasure;
    logic [CW-1:0]   r_x, r_y, r_run, r_hActive, r_vActive, r_activeLines;
    logic            r_deOut, r_frameStart, r_locked;
    logic            w_lineActive;
    logic [CW-1:0]   w_hTotalNow, w_hActiveNow, w_activeNow;
    logic [4*CW-1:0] w_snap, r_prevSnap;
    logic            w_snapValid, w_timeout;
    lock_state_t     r_state;

    // First input stage plus the second de stage used for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hsQ  <= 1'b0;
            r_vsQ  <= 1'b0;
            r_deQ  <= 1'b0;
            r_deQ2 <= 1'b0;
        end else begin
            r_hsQ  <= i_hsync;
            r_vsQ  <= i_vsync;
            r_deQ  <= i_de;
            r_deQ2 <= r_deQ;
        end
    end

    assign w_deRise = r_deQ & ~r_deQ2;
    assign w_deFall = ~r_deQ & r_deQ2;

`ifdef POLARITY_DETECT_EN
    logic r_hpol, r_vpol;

    // Sync levels seen at the start of active video are the inactive levels
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hpol <= 1'b0;
            r_vpol <= 1'b0;
        end else if (w_deRise) begin
            r_hpol <= r_hsQ;
            r_vpol <= r_vsQ;
        end
    end

    assign w_hpol = r_hpol;
    assign w_vpol = r_vpol;
`else
    assign w_hpol = 1'b0;
    assign w_vpol = 1'b0;
`endif

    assign w_hs   = r_hsQ ^ w_hpol;
    assign w_vs   = r_vsQ ^ w_vpol;
    assign o_hpol = w_hpol;
    assign o_vpol = w_vpol;

    sync_edge_meter #(.CW(CW)) u_hMeter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_sync    (w_hs),
        .i_en      (1'b1),
        .o_rise    (w_hsRise),
        .o_period  (w_hTotal),
        .o_measure (w_hMeasure),
        .o_sat     (w_hSat)
    );

    sync_edge_meter #(.CW(CW)) u_vMeter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_sync    (w_vs),
        .i_en      (w_hsRise),
        .o_rise    (w_vsRise),
        .o_period  (w_vTotal),
        .o_measure (w_vMeasure),
        .o_sat     (w_vSat)
    );

    assign w_lineActive = w_hsRise && (r_run != '0);
    assign w_activeNow  = (w_lineActive && (r_activeLines != CMAX)) ?
                          r_activeLines + 1'b1 : r_activeLines;

    // Per-line de run length and per-frame count of lines that carried de
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run         <= '0;
            r_hActive     <= '0;
            r_vActive     <= '0;
            r_activeLines <= '0;
        end else begin
            if (w_hsRise) begin
                r_run <= '0;
            end else if (r_deQ && (r_run != CMAX)) begin
                r_run <= r_run + 1'b1;
            end
            if (w_lineActive) begin
                r_hActive <= r_run;
            end
            if (w_vsRise) begin
                r_vActive     <= w_activeNow;
                r_activeLines <= '0;
            end else begin
                r_activeLines <= w_activeNow;
            end
        end
    end

    // Active coordinates, aligned de and frame start pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_deOut      <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_deOut      <= r_deQ;
            r_frameStart <= w_vsRise;
            if (w_deRise) begin
                r_x <= '0;
            end else if (r_deQ) begin
                r_x <= r_x + 1'b1;
            end
            if (w_vsRise) begin
                r_y <= '0;
            end else if (w_deFall) begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    // Snapshot reflects values latched this very cycle so lock moves with frame_start
    assign w_hTotalNow  = w_hsRise ? w_hMeasure : w_hTotal;
    assign w_hActiveNow = w_lineActive ? r_run : r_hActive;
    assign w_snap       = {w_hTotalNow, w_hActiveNow, w_vMeasure, w_activeNow};
    assign w_snapValid  = (w_hTotalNow != '0) && (w_hActiveNow != '0) &&
                          (w_vMeasure != '0) && (w_activeNow != '0);
    assign w_timeout    = w_hSat | w_vSat;

    // Lock FSM: compare consecutive frame snapshots on each vsync rise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= SEARCH;
            r_locked   <= 1'b0;
            r_prevSnap <= '0;
        end else if (w_timeout) begin
            r_state    <= SEARCH;
            r_locked   <= 1'b0;
            r_prevSnap <= '0;
        end else if (w_vsRise) begin
            unique case (r_state)
                SEARCH: begin
                    r_state    <= MEASURE;
                    r_locked   <= 1'b0;
                    r_prevSnap <= '0;
                end
                MEASURE: begin
                    r_prevSnap <= w_snap;
                    if (w_snapValid && (w_snap == r_prevSnap)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    r_prevSnap <= w_snap;
                    if (w_snap != r_prevSnap) begin
                        r_state  <= MEASURE;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_de_out      = r_deOut;
    assign o_frame_start = r_frameStart;
    assign o_h_total     = w_hTotal;
    assign o_h_active    = r_hActive;
    assign o_v_total     = w_vTotal;
    assign o_v_active    = r_vActive;
    assign o_locked      = r_locked;

endmodule

// File: tb/tb_video_timing_detector.sv
// Directed bench for video_timing_detector. The detector does not depend on
// raster size, so a scaled-down raster keeps the run short; the timeout still
// uses the full 12-bit counter ceiling.
module tb_video_timing_detector;

    localparam int CW         = 12;
    localparam int H_TOT      = 40;
    localparam int H_ALT      = 43;
    localparam int H_ACT      = 32;
    localparam int HS_START   = 34;
    localparam int HS_END     = 37;
    localparam int V_TOT      = 30;
    localparam int V_ACT      = 24;
    localparam int VS_START   = 26;
    localparam int VS_END     = 27;
    localparam int RST_LINE   = 12;

    logic          clk = 1'b0;
    logic          rst, hsync, vsync, de;
    logic [CW-1:0] o_x, o_y, o_h_total, o_h_active, o_v_total, o_v_active;
    logic          o_de_out, o_frame_start, o_locked, o_hpol, o_vpol;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int firstX, firstY, lastX, lastY, inCyc, outCyc;
    int fsCount, fsRun, fsMaxRun;
    bit seenIn, seenDe;

    video_timing_detector #(.CW(CW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_hsync       (hsync),
        .i_vsync       (vsync),
        .i_de          (de),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_de_out      (o_de_out),
        .o_frame_start (o_frame_start),
        .o_h_total     (o_h_total),
        .o_h_active    (o_h_active),
        .o_v_total     (o_v_total),
        .o_v_active    (o_v_active),
        .o_locked      (o_locked),
        .o_hpol        (o_hpol),
        .o_vpol        (o_vpol)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic observe();
        if (o_de_out) begin
            if (!seenDe) begin
                seenDe = 1'b1;
                firstX = int'(o_x);
                firstY = int'(o_y);
                outCyc = cyc;
            end
            lastX = int'(o_x);
            lastY = int'(o_y);
        end
        if (o_frame_start) begin
            fsRun++;
            if (fsRun == 1) fsCount++;
            if (fsRun > fsMaxRun) fsMaxRun = fsRun;
        end else begin
            fsRun = 0;
        end
    endtask

    task automatic clearCapture();
        seenIn = 1'b0;  seenDe = 1'b0;
        firstX = -1;    firstY = -1;  lastX = -1;  lastY = -1;
        inCyc = 0;      outCyc = 0;
        fsCount = 0;    fsRun = 0;    fsMaxRun = 0;
    endtask

    // Drives lines firstLine..lastLine of a raster with the given line length
    task automatic applyStimulus(input int hTot, input bit inv, input int firstLine, input int lastLine);
        for (int ln = firstLine; ln <= lastLine; ln++) begin
            for (int px = 0; px < hTot; px++) begin
                de    = (px < H_ACT) && (ln < V_ACT);
                hsync = ((px >= HS_START) && (px <= HS_END)) ^ inv;
                vsync = ((ln >= VS_START) && (ln <= VS_END)) ^ inv;
                if (de && !seenIn) begin
                    seenIn = 1'b1;
                    inCyc  = cyc;
                end
                tick();
                observe();
            end
        end
    endtask

    task automatic idle(input int n);
        hsync = 1'b0;
        vsync = 1'b0;
        de    = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        clearCapture();
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        repeat (3) tick();
        checkOutput("reset_x",        int'(o_x), 0);
        checkOutput("reset_y",        int'(o_y), 0);
        checkOutput("reset_de_out",   int'(o_de_out), 0);
        checkOutput("reset_fs",       int'(o_frame_start), 0);
        checkOutput("reset_h_total",  int'(o_h_total), 0);
        checkOutput("reset_h_active", int'(o_h_active), 0);
        checkOutput("reset_v_total",  int'(o_v_total), 0);
        checkOutput("reset_v_active", int'(o_v_active), 0);
        checkOutput("reset_locked",   int'(o_locked), 0);
        checkOutput("reset_hpol",     int'(o_hpol), 0);
        checkOutput("reset_vpol",     int'(o_vpol), 0);
        rst = 1'b0;

        $display("[TB] nominal raster");
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("nom_locked_after_2", int'(o_locked), 0);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("nom_locked",   int'(o_locked), 1);
        checkOutput("nom_h_total",  int'(o_h_total), H_TOT);
        checkOutput("nom_h_active", int'(o_h_active), H_ACT);
        checkOutput("nom_v_total",  int'(o_v_total), V_TOT);
        checkOutput("nom_v_active", int'(o_v_active), V_ACT);
        checkOutput("nom_hpol",     int'(o_hpol), 0);
        checkOutput("nom_vpol",     int'(o_vpol), 0);

        $display("[TB] coordinates");
        clearCapture();
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("coord_first_x",  firstX, 0);
        checkOutput("coord_first_y",  firstY, 0);
        checkOutput("coord_last_x",   lastX, H_ACT-1);
        checkOutput("coord_last_y",   lastY, V_ACT-1);
        checkOutput("coord_latency",  outCyc - inCyc, 2);
        checkOutput("fs_pulses",      fsCount, 1);
        checkOutput("fs_width",       fsMaxRun, 1);
        checkOutput("coord_locked",   int'(o_locked), 1);

        $display("[TB] geometry change");
        applyStimulus(H_ALT, 1'b0, 0, V_TOT-1);
        checkOutput("geo_unlocked", int'(o_locked), 0);
        checkOutput("geo_h_total",  int'(o_h_total), H_ALT);
        applyStimulus(H_ALT, 1'b0, 0, V_TOT-1);
        checkOutput("geo_relocked", int'(o_locked), 1);
        checkOutput("geo_h_active", int'(o_h_active), H_ACT);
        checkOutput("geo_v_total",  int'(o_v_total), V_TOT);
        checkOutput("geo_v_active", int'(o_v_active), V_ACT);

        $display("[TB] loss of signal");
        idle(3000);
        checkOutput("los_still_locked", int'(o_locked), 1);
        idle(1200);
        checkOutput("los_unlocked", int'(o_locked), 0);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("los_locked_after_2", int'(o_locked), 0);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("los_relocked", int'(o_locked), 1);
        checkOutput("los_h_total",  int'(o_h_total), H_TOT);
        checkOutput("los_v_total",  int'(o_v_total), V_TOT);

        $display("[TB] mid-frame reset");
        applyStimulus(H_TOT, 1'b0, 0, RST_LINE-1);
        checkOutput("mrst_pre_locked", int'(o_locked), 1);
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; de = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst_x",        int'(o_x), 0);
        checkOutput("mrst_y",        int'(o_y), 0);
        checkOutput("mrst_de_out",   int'(o_de_out), 0);
        checkOutput("mrst_fs",       int'(o_frame_start), 0);
        checkOutput("mrst_h_total",  int'(o_h_total), 0);
        checkOutput("mrst_h_active", int'(o_h_active), 0);
        checkOutput("mrst_v_total",  int'(o_v_total), 0);
        checkOutput("mrst_v_active", int'(o_v_active), 0);
        checkOutput("mrst_locked",   int'(o_locked), 0);
        applyStimulus(H_TOT, 1'b0, RST_LINE, V_TOT-1);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("mrst_locked_after_2", int'(o_locked), 0);
        applyStimulus(H_TOT, 1'b0, 0, V_TOT-1);
        checkOutput("mrst_relocked", int'(o_locked), 1);
        checkOutput("mrst_h_total2", int'(o_h_total), H_TOT);

`ifdef POLARITY_DETECT_EN
        $display("[TB] inverted sync polarity");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(H_TOT, 1'b1, 0, V_TOT-1);
        applyStimulus(H_TOT, 1'b1, 0, V_TOT-1);
        applyStimulus(H_TOT, 1'b1, 0, V_TOT-1);
        checkOutput("pol_hpol",     int'(o_hpol), 1);
        checkOutput("pol_vpol",     int'(o_vpol), 1);
        checkOutput("pol_locked",   int'(o_locked), 1);
        checkOutput("pol_h_total",  int'(o_h_total), H_TOT);
        checkOutput("pol_h_active", int'(o_h_active), H_ACT);
        checkOutput("pol_v_total",  int'(o_v_total), V_TOT);
        checkOutput("pol_v_active", int'(o_v_active), V_ACT);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_timing_detector.md
Name: video_timing_detector

Overview:
- Receive-side counterpart of the 640x480 timing generator.
- Consumes a pixel-synchronous hsync/vsync/de stream and measures the line and frame geometry (totals and active sizes).
- Recovers active-pixel coordinates and declares lock once two consecutive frames measure identically.
- Sits at the front of the HDMI capture path and feeds coordinates to downstream pixel logic.

Parameters:
- CW, 12, width of all counters and measurement outputs; saturating ceiling is 2^CW-1.

Ports:
- clk  in  1  pixel clock; all inputs are synchronous to it
- rst  in  1  synchronous reset, active-high
- hsync  in  1  horizontal sync, active-high
- vsync  in  1  vertical sync, active-high
- de  in  1  data enable (active video)
- x  out  CW  column of current active pixel, 0-based
- y  out  CW  active line index, 0-based
- de_out  out  1  de delayed to align with x/y
- frame_start  out  1  one-cycle pulse on vsync rising edge
- h_total  out  CW  clocks between hsync rising edges
- h_active  out  CW  de-high clocks in the last line containing de
- v_total  out  CW  hsync rising edges per frame
- v_active  out  CW  lines containing de per frame
- locked  out  1  geometry stable
- hpol  out  1  detected hsync inversion (see Optional Feature)
- vpol  out  1  detected vsync inversion (see Optional Feature)

Behaviour:
- Inputs registered once (hs_q, vs_q, de_q); edges are detected against a second stage.
- All outputs are registered.
- Total latency from input pins to de_out/x/y/frame_start is 2 clocks.
- Reset: all outputs 0, all counters 0, state SEARCH.
- Horizontal:
  - hcnt increments every clock and saturates at 2^CW-1.
  - On hsync rise: h_total <= hcnt+1, hcnt <= 0, line counter +1.
  - The same edge also ends the per-line de run counter: if it is nonzero, h_active <= run and the line is flagged active.
- x counting:
  - x <= 0 on the de rising edge.
  - Otherwise x increments while de_q is high.
  - x holds when de is low.
- y counting:
  - y increments on each de falling edge.
  - On vsync rise y <= 0; vsync takes priority over a simultaneous de fall.
- Vertical: on vsync rise:
  - v_total <= line count, v_active <= active-line count; both counters then clear.
  - frame_start pulses.
  - The lock FSM is evaluated.
- Lock FSM, SEARCH/MEASURE/LOCKED, evaluated only on vsync rise unless timeout:
  - SEARCH -> MEASURE at the first vsync rise; counts so far are discarded, so no compare is made.
  - MEASURE: the snapshot is compared with the previous snapshot. If all four values are equal and nonzero -> LOCKED; else stay in MEASURE.
  - LOCKED: any mismatch -> MEASURE and locked deasserts.
  - Timeout: hcnt or the line counter saturating -> SEARCH from any state; locked <= 0 and the snapshots clear.
- locked changes in the same cycle frame_start pulses, except on timeout.
- Measurement outputs update every frame regardless of lock.
- Reset asserted mid-frame returns everything to the reset state the next clock.

Optional Feature:
- Macro: POLARITY_DETECT_EN.
- Enabled:
  - On each de rising edge, hs_q and vs_q are latched as the inactive sync levels.
  - hpol/vpol equal those latched values.
  - Internal sync = hs_q ^ hpol and vs_q ^ vpol, so active-low sync is measured correctly after the first active line.
- Disabled: hpol/vpol tied 0 and sync is taken as active-high.

Decomposition:
- Package video_timing_pkg holds:
  - default CW
  - the lock FSM state enum
  - 480p nominal constants: H_TOTAL 800, H_ACTIVE 640, V_TOTAL 525, V_ACTIVE 480, H_SYNC 656..751, V_SYNC 490..491.
- Sub-module sync_edge_meter: registered rising-edge detect plus saturating period counter with a latched result.
- sync_edge_meter is instantiated twice: once for hsync (clocks), once for vsync (lines, enabled by the hsync edge).

Test Plan:
- Nominal 480p:
  - Stimulus: reset, then a standard 800x525 stream (sync 656..751 / 490..491).
  - Required: after the 3rd vsync rise, locked=1, h_total=800, h_active=640, v_total=525, v_active=480.
- Coordinates:
  - Stimulus: locked 480p stream.
  - Required: first de_out cycle of a frame shows x=0,y=0; last shows x=639,y=479; both appear 2 clocks after input de; frame_start is a single-cycle pulse.
- Geometry change:
  - Stimulus: while locked, switch to h_total 858.
  - Required: locked drops at the next vsync rise and h_total=858; locked reasserts one frame later.
- Loss of signal:
  - Stimulus: hold hsync low.
  - Required: after 2^12-1 clocks, state SEARCH, locked=0; recovery takes 3 vsync rises.
- Mid-frame reset:
  - Stimulus: assert rst for 1 clock at line 200.
  - Required: all outputs 0 next clock; lock is regained on the 3rd subsequent vsync rise.
- Polarity (POLARITY_DETECT_EN defined):
  - Stimulus: inverted hsync/vsync.
  - Required: hpol=vpol=1 after the first active line; measurements equal the nominal case and lock is achieved.
